// File: rtl/snoop_memory_responder.sv
// snoop_memory_responder
// Shared-memory end of the snooping bus. It answers ReadMiss requests with a
// ReadHit data reply after a fixed snoop window and absorbs WriteBack traffic
// into an 8 x 4-bit backing store. If a cache writes back the requested line
// during the snoop window, it has supplied the data itself, so the memory
// reply is cancelled.
//
// Bus handshake: bus_valid qualifies bus_in for exactly the cycle it is high.
// There is no ready signal. While busy is high, ReadMiss messages are dropped
// and the initiator must retry. WriteBack messages are always accepted.
// bus_out_valid is a one-cycle strobe, and bus_out is all-zero whenever the
// strobe is low.
module snoop_memory_responder #(
    // Snoop window length in cycles; meaningful range is 1..7 (3-bit counter).
    parameter int SNOOP_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_valid,
    input  logic [8:0] bus_in,
    output logic [8:0] bus_out,
    output logic       bus_out_valid,
    output logic       busy,
    output logic [7:0] reply_count,
    input  logic [2:0] dbg_addr,
    output logic [3:0] dbg_data
);

    localparam logic [1:0] READ_MISS  = 2'b10;
    localparam logic [1:0] READ_HIT   = 2'b01;
    localparam logic [1:0] WRITE_BACK = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SNOOP   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  tag_q, tag_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  mem_q [8];

    logic [8:0]  bus_out_d;
    logic        bus_out_valid_d;
    logic        busy_d;
    logic [7:0]  reply_count_d;

    // Decoded fields of the incoming message
    logic [1:0]  msg_type;
    logic [2:0]  msg_tag;
    logic [3:0]  msg_data;
    logic        is_read_miss;
    logic        is_write_back;
    logic        wb_same_tag;
    logic [3:0]  reply_data;

    // Split the bus message and qualify the two message types we act on
    always_comb begin
        msg_type      = bus_in[8:7];
        msg_tag       = bus_in[6:4];
        msg_data      = bus_in[3:0];
        is_read_miss  = bus_valid && (msg_type == READ_MISS);
        is_write_back = bus_valid && (msg_type == WRITE_BACK);
        wb_same_tag   = is_write_back && (msg_tag == tag_q);
        // A same-tag write-back in the reply cycle is forwarded so the reply
        // never carries data older than what memory is about to hold.
        reply_data    = wb_same_tag ? msg_data : mem_q[tag_q];
    end

    // Next-state and next-output decode for the request FSM
    always_comb begin
        state_d         = state_q;
        tag_d           = tag_q;
        cnt_d           = cnt_q;
        bus_out_d       = '0;
        bus_out_valid_d = 1'b0;
        reply_count_d   = reply_count;

        case (state_q)
            IDLE: begin
                if (is_read_miss) begin
                    tag_d   = msg_tag;
                    cnt_d   = 3'(SNOOP_WAIT);
                    state_d = SNOOP;
                end
            end

            SNOOP: begin
                cnt_d = cnt_q - 3'd1;
                if (wb_same_tag) begin
                    // Owning cache supplied the line: drop our reply.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == 3'd1) begin
                    state_d = RESPOND;
                end
            end

            RESPOND: begin
                bus_out_d       = {READ_HIT, tag_q, reply_data};
                bus_out_valid_d = 1'b1;
                if (reply_count != 8'hFF) begin
                    reply_count_d = reply_count + 8'd1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state, latched request and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tag_q         <= '0;
            cnt_q         <= '0;
            bus_out       <= '0;
            bus_out_valid <= 1'b0;
            busy          <= 1'b0;
            reply_count   <= '0;
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            cnt_q         <= cnt_d;
            bus_out       <= bus_out_d;
            bus_out_valid <= bus_out_valid_d;
            busy          <= busy_d;
            reply_count   <= reply_count_d;
        end
    end

    // Backing store: reset image, then write-backs land in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 4'd1;
            mem_q[1] <= 4'd0;
            mem_q[2] <= 4'd1;
            mem_q[3] <= 4'd2;
            mem_q[4] <= 4'd3;
            mem_q[5] <= 4'd4;
            mem_q[6] <= 4'd5;
            mem_q[7] <= 4'd6;
        end else if (is_write_back) begin
            mem_q[msg_tag] <= msg_data;
        end
    end

    // Debug read port, purely combinational
    always_comb begin
        dbg_data = mem_q[dbg_addr];
    end

endmodule
